vec_checker: RTL and testbench
==============================

# vec_checker

Hardware self-check stage that sits directly downstream of a combinational DUT (e.g. the inverter) in the bench/FPGA test harness. Each valid cycle it compares the DUT output against an expected vector with a per-bit don't-care mask, and counts tests and errors. After `MAX_VECTORS` vectors it halts and raises `done`/`pass`. This replaces the per-cycle software compare with a synthesizable checker that can run on silicon.

## Interface
- `WIDTH`, 1, bit width of DUT output / expected / mask
- `MAX_VECTORS`, 2, vectors per run; must be ≥1
- `CW`, `$clog2(MAX_VECTORS+1)`, counter width (derived, localparam)

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — begin a run (level sampled on the clock edge)
- `vec_valid` in 1 — `dut_y`/`exp_y`/`exp_mask` valid this cycle
- `dut_y` in WIDTH — actual DUT output
- `exp_y` in WIDTH — expected output
- `exp_mask` in WIDTH — 1 = don't-care bit (stands in for `x` in vector files)
- `ready` out 1 — checker accepts vectors (state RUN)
- `busy` out 1 — run in progress
- `done` out 1 — run complete, counters frozen
- `pass` out 1 — `done` and zero errors
- `test_count` out CW — vectors accepted this run
- `error_count` out CW — mismatching vectors this run
- `first_err_idx` out CW — 0-based index of the first failing vector
- `first_err_vld` out 1 — `first_err_idx` holds a valid index

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `start`=1 → RUN; counters, `first_err_*` cleared.
  - `vec_valid` is ignored.
- RUN:
  - Accept = `vec_valid & ready`.
  - On accept: `mismatch = |((dut_y ^ exp_y) & ~exp_mask)`; `test_count++`; if mismatch then `error_count++`.
  - The first mismatch of the run latches `first_err_idx = test_count` (pre-increment value) and sets `first_err_vld`.
  - When an accepted vector brings `test_count` to `MAX_VECTORS` → DONE.
  - `start` in RUN is ignored.
- DONE:
  - Outputs frozen; `vec_valid` ignored.
  - `start`=1 → clear counters and `first_err_*`, then RUN.
- A fully masked vector (`exp_mask` all ones) counts as a test and never as an error.
- `error_count` ≤ `test_count` ≤ `MAX_VECTORS`, so no overflow is possible at `CW`.
- Outputs:
  - `ready`=`busy`= (state==RUN).
  - `done` = (state==DONE).
  - `pass` = `done & (error_count==0)`.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE; `ready`=0, `busy`=0, `done`=0, `pass`=0, `test_count`=0, `error_count`=0, `first_err_idx`=0, `first_err_vld`=0.
- `start` sampled at edge N → `ready`=1 from edge N onward. The first vector can be accepted at edge N+1.
- Compare latency 1 cycle: a vector accepted at edge K updates the counters, visible after edge K.
- The last vector accepted at edge K → `done`/`pass` valid after edge K; `ready` drops the same edge.
- `start` and `vec_valid` in the same IDLE cycle: start taken, vector dropped (not counted).
- `rst_n` low mid-run: everything returns to reset values asynchronously. The run is lost and no `done` is produced.
- Back-to-back vectors every cycle are supported (throughput 1/cycle).

## Configuration
- `VEC_CHECKER_STOP_ON_ERR_EN` defined:
  - An accepted mismatching vector moves RUN → DONE on the same edge; `test_count` includes the failing vector.
  - `pass`=0 and `done`=1.
- Not defined: the run always continues to `MAX_VECTORS` regardless of errors.

## Test plan
- WIDTH=1, MAX=2, inverter vectors (a=0,exp=1),(a=1,exp=0), DUT correct → `done`=1, `pass`=1, `test_count`=2, `error_count`=0, `first_err_vld`=0.
- Same bench, second vector with `dut_y` forced 1 → `error_count`=1, `first_err_idx`=1, `first_err_vld`=1, `pass`=0.
- Mask test: `exp_mask`=1 with mismatching `dut_y` on vector 0, vector 1 matches → `error_count`=0, `pass`=1.
- `vec_valid` held high in IDLE for 3 cycles, then `start` with `vec_valid`=1 → `test_count` stays 0 until the cycle after start; the final `test_count`=2.
- `rst_n` pulsed low after 1 accepted vector → all outputs 0 immediately. A new `start` gives a clean run with `test_count`=2.
- With `VEC_CHECKER_STOP_ON_ERR_EN`, MAX=4, mismatch at vector 1 → `done`=1 after vector 1, `test_count`=2, `error_count`=1. Later vectors are ignored.

Source files
------------

// File: rtl/vec_checker_if.sv
// rtl/vec_checker_if.sv - vector stream and status bundle for vec_checker
interface vec_checker_if #(
    parameter int WIDTH       = 1,
    parameter int MAX_VECTORS = 2
);
    localparam int CW = $clog2(MAX_VECTORS + 1);

    logic             start;
    logic             vec_valid;
    logic [WIDTH-1:0] dut_y;
    logic [WIDTH-1:0] exp_y;
    logic [WIDTH-1:0] exp_mask;
    logic             ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CW-1:0]    test_count;
    logic [CW-1:0]    error_count;
    logic [CW-1:0]    first_err_idx;
    logic             first_err_vld;

    // Harness side: drives vectors and run control, observes status.
    modport master (
        output start, vec_valid, dut_y, exp_y, exp_mask,
        input  ready, busy, done, pass, test_count, error_count,
               first_err_idx, first_err_vld
    );

    // Checker side.
    modport slave (
        input  start, vec_valid, dut_y, exp_y, exp_mask,
        output ready, busy, done, pass, test_count, error_count,
               first_err_idx, first_err_vld
    );
endinterface

// File: rtl/vec_checker.sv
// rtl/vec_checker.sv - masked vector compare and pass/fail counter (optional VEC_CHECKER_STOP_ON_ERR_EN)
module vec_checker #(
    parameter int WIDTH       = 1,
    parameter int MAX_VECTORS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    vec_checker_if.slave bus
);
    localparam int CW = $clog2(MAX_VECTORS + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_VECTORS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    test_count;
    logic [CW-1:0]    error_count;
    logic [CW-1:0]    first_err_idx;
    logic             first_err_vld;
    logic [WIDTH-1:0] diff;
    logic             mismatch;

    // Masked bits behave like 'x' entries in a vector file: never a mismatch.
    assign diff     = (bus.dut_y ^ bus.exp_y) & ~bus.exp_mask;
    assign mismatch = |diff;

    // Run control and counters; ready is state==RUN, so accept is vec_valid in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            test_count    <= '0;
            error_count   <= '0;
            first_err_idx <= '0;
            first_err_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state         <= S_RUN;
                        test_count    <= '0;
                        error_count   <= '0;
                        first_err_idx <= '0;
                        first_err_vld <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.vec_valid) begin
                        test_count <= test_count + 1'b1;
                        if (mismatch) begin
                            error_count <= error_count + 1'b1;
                            if (!first_err_vld) begin
                                first_err_idx <= test_count;
                                first_err_vld <= 1'b1;
                            end
                        end
`ifdef VEC_CHECKER_STOP_ON_ERR_EN
                        if (mismatch || test_count == LAST) begin
                            state <= S_DONE;
                        end
`else
                        if (test_count == LAST) begin
                            state <= S_DONE;
                        end
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready         = (state == S_RUN);
    assign bus.busy          = (state == S_RUN);
    assign bus.done          = (state == S_DONE);
    assign bus.pass          = (state == S_DONE) && (error_count == '0);
    assign bus.test_count    = test_count;
    assign bus.error_count   = error_count;
    assign bus.first_err_idx = first_err_idx;
    assign bus.first_err_vld = first_err_vld;
endmodule

// File: tb/tb_vec_checker.sv
// tb/tb_vec_checker.sv - directed self-checking bench for vec_checker
module tb_vec_checker;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    vec_checker_if #(.WIDTH(1), .MAX_VECTORS(2)) bus ();
    vec_checker_if #(.WIDTH(4), .MAX_VECTORS(4)) bus4 ();

    vec_checker #(.WIDTH(1), .MAX_VECTORS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_checker #(.WIDTH(4), .MAX_VECTORS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic y, input logic e, input logic m);
        bus.vec_valid = 1'b1;
        bus.dut_y     = y;
        bus.exp_y     = e;
        bus.exp_mask  = m;
        step();
        bus.vec_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] y, input logic [3:0] e, input logic [3:0] m);
        bus4.vec_valid = 1'b1;
        bus4.dut_y     = y;
        bus4.exp_y     = e;
        bus4.exp_mask  = m;
        step();
        bus4.vec_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 0; bus.vec_valid = 0; bus.dut_y = 0; bus.exp_y = 0; bus.exp_mask = 0;
        bus4.start = 0; bus4.vec_valid = 0; bus4.dut_y = 0; bus4.exp_y = 0; bus4.exp_mask = 0;
        step();
        step();
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.pass, bus.first_err_vld} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.ready, bus.busy, bus.done, bus.pass, bus.first_err_vld});
        end
        checks++;
        if ({bus.test_count, bus.error_count, bus.first_err_idx} !== 6'b0) begin
            failures++;
            $display("FAIL reset_counts got=%h exp=0",
                     {bus.test_count, bus.error_count, bus.first_err_idx});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_inverter_pass();
        do_start();
        checks++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b1 || bus.test_count !== 2'd0) begin
            failures++;
            $display("FAIL start_ready got ready=%b busy=%b tc=%0d exp 1 1 0",
                     bus.ready, bus.busy, bus.test_count);
        end
        send(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.test_count !== 2'd1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL pass_v0 got tc=%0d done=%b exp 1 0", bus.test_count, bus.done);
        end
        send(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL pass_done got done=%b pass=%b ready=%b exp 1 1 0",
                     bus.done, bus.pass, bus.ready);
        end
        checks++;
        if (bus.test_count !== 2'd2 || bus.error_count !== 2'd0 || bus.first_err_vld !== 1'b0) begin
            failures++;
            $display("FAIL pass_counts got tc=%0d ec=%0d fv=%b exp 2 0 0",
                     bus.test_count, bus.error_count, bus.first_err_vld);
        end
        send(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.test_count !== 2'd2 || bus.error_count !== 2'd0 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL done_frozen got tc=%0d ec=%0d done=%b exp 2 0 1",
                     bus.test_count, bus.error_count, bus.done);
        end
    endtask

    task automatic test_error();
        do_start();
        checks++;
        if (bus.test_count !== 2'd0 || bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear got tc=%0d done=%b ready=%b exp 0 0 1",
                     bus.test_count, bus.done, bus.ready);
        end
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.error_count !== 2'd1 || bus.first_err_idx !== 2'd1 || bus.first_err_vld !== 1'b1) begin
            failures++;
            $display("FAIL err_counts got ec=%0d idx=%0d fv=%b exp 1 1 1",
                     bus.error_count, bus.first_err_idx, bus.first_err_vld);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b0 || bus.test_count !== 2'd2) begin
            failures++;
            $display("FAIL err_done got done=%b pass=%b tc=%0d exp 1 0 2",
                     bus.done, bus.pass, bus.test_count);
        end
    endtask

    task automatic test_mask();
        do_start();
        checks++;
        if (bus.first_err_vld !== 1'b0 || bus.error_count !== 2'd0) begin
            failures++;
            $display("FAIL mask_clear got fv=%b ec=%0d exp 0 0", bus.first_err_vld, bus.error_count);
        end
        send(1'b0, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.error_count !== 2'd0 || bus.pass !== 1'b1 || bus.test_count !== 2'd2) begin
            failures++;
            $display("FAIL mask_result got ec=%0d pass=%b tc=%0d exp 0 1 2",
                     bus.error_count, bus.pass, bus.test_count);
        end
    endtask

    task automatic test_idle_valid();
        pulse_reset();
        bus.vec_valid = 1'b1;
        bus.dut_y     = 1'b1;
        bus.exp_y     = 1'b1;
        bus.exp_mask  = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.test_count !== 2'd0 || bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore got tc=%0d ready=%b exp 0 0", bus.test_count, bus.ready);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.test_count !== 2'd0 || bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL start_drop got tc=%0d ready=%b exp 0 1", bus.test_count, bus.ready);
        end
        step();
        checks++;
        if (bus.test_count !== 2'd1) begin
            failures++;
            $display("FAIL b2b_first got tc=%0d exp 1", bus.test_count);
        end
        step();
        bus.vec_valid = 1'b0;
        checks++;
        if (bus.test_count !== 2'd2 || bus.done !== 1'b1 || bus.pass !== 1'b1) begin
            failures++;
            $display("FAIL b2b_final got tc=%0d done=%b pass=%b exp 2 1 1",
                     bus.test_count, bus.done, bus.pass);
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        send(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.test_count !== 2'd1 || bus.error_count !== 2'd1 || bus.first_err_vld !== 1'b1) begin
            failures++;
            $display("FAIL midrun_pre got tc=%0d ec=%0d fv=%b exp 1 1 1",
                     bus.test_count, bus.error_count, bus.first_err_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.busy, bus.done, bus.pass, bus.first_err_vld,
             bus.test_count, bus.error_count, bus.first_err_idx} !== 11'b0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0",
                     {bus.ready, bus.busy, bus.done, bus.pass, bus.first_err_vld,
                      bus.test_count, bus.error_count, bus.first_err_idx});
        end
        step();
        rst_n = 1'b1;
        step();
        do_start();
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.test_count !== 2'd2 || bus.pass !== 1'b1 || bus.first_err_vld !== 1'b0) begin
            failures++;
            $display("FAIL clean_rerun got tc=%0d pass=%b fv=%b exp 2 1 0",
                     bus.test_count, bus.pass, bus.first_err_vld);
        end
    endtask

    task automatic test_stop_on_err();
        bus4.start = 1'b1;
        step();
        bus4.start = 1'b0;
        send4(4'hB, 4'hA, 4'h1);
        checks++;
        if (bus4.test_count !== 3'd1 || bus4.error_count !== 3'd0) begin
            failures++;
            $display("FAIL w4_partial_mask got tc=%0d ec=%0d exp 1 0",
                     bus4.test_count, bus4.error_count);
        end
        send4(4'h5, 4'h4, 4'h0);
`ifdef VEC_CHECKER_STOP_ON_ERR_EN
        checks++;
        if (bus4.done !== 1'b1 || bus4.pass !== 1'b0 || bus4.test_count !== 3'd2 ||
            bus4.error_count !== 3'd1 || bus4.first_err_idx !== 3'd1) begin
            failures++;
            $display("FAIL stop_err got done=%b pass=%b tc=%0d ec=%0d idx=%0d exp 1 0 2 1 1",
                     bus4.done, bus4.pass, bus4.test_count, bus4.error_count, bus4.first_err_idx);
        end
        send4(4'h3, 4'h0, 4'h0);
        checks++;
        if (bus4.test_count !== 3'd2 || bus4.error_count !== 3'd1) begin
            failures++;
            $display("FAIL stop_ignore got tc=%0d ec=%0d exp 2 1",
                     bus4.test_count, bus4.error_count);
        end
`else
        checks++;
        if (bus4.done !== 1'b0 || bus4.ready !== 1'b1 || bus4.test_count !== 3'd2 ||
            bus4.first_err_idx !== 3'd1 || bus4.first_err_vld !== 1'b1) begin
            failures++;
            $display("FAIL cont_mid got done=%b ready=%b tc=%0d idx=%0d fv=%b exp 0 1 2 1 1",
                     bus4.done, bus4.ready, bus4.test_count, bus4.first_err_idx, bus4.first_err_vld);
        end
        send4(4'h3, 4'h3, 4'h0);
        send4(4'hF, 4'h0, 4'hF);
        checks++;
        if (bus4.done !== 1'b1 || bus4.pass !== 1'b0 || bus4.test_count !== 3'd4 ||
            bus4.error_count !== 3'd1 || bus4.first_err_idx !== 3'd1) begin
            failures++;
            $display("FAIL cont_end got done=%b pass=%b tc=%0d ec=%0d idx=%0d exp 1 0 4 1 1",
                     bus4.done, bus4.pass, bus4.test_count, bus4.error_count, bus4.first_err_idx);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_inverter_pass();
        test_error();
        test_mask();
        test_idle_valid();
        test_reset_midrun();
        test_stop_on_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
